// File: rtl/fpga_mem_bridge_if.sv
// Signal bundle between the calculator front-end, the shared data-memory port
// and the FPGA memory bridge. The bridge uses the master view; its environment uses slave.
interface fpga_mem_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          fpga_wr_en;
    logic [AW-1:0] fpga_wr_addr;
    logic [DW-1:0] fpga_wr_data;
    logic          fpga_rd_en;
    logic [AW-1:0] fpga_rd_addr;
    logic          cpu_run_req;
    logic          cpu_mem_req;
    logic [DW-1:0] mem_rdata;

    logic          fpga_sel;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          cpu_run;
    logic          fifo_full;
    logic          overflow;

    modport master (
        input  fpga_wr_en,
        input  fpga_wr_addr,
        input  fpga_wr_data,
        input  fpga_rd_en,
        input  fpga_rd_addr,
        input  cpu_run_req,
        input  cpu_mem_req,
        input  mem_rdata,
        output fpga_sel,
        output mem_we,
        output mem_re,
        output mem_addr,
        output mem_wdata,
        output rd_data,
        output rd_valid,
        output cpu_run,
        output fifo_full,
        output overflow
    );

    modport slave (
        output fpga_wr_en,
        output fpga_wr_addr,
        output fpga_wr_data,
        output fpga_rd_en,
        output fpga_rd_addr,
        output cpu_run_req,
        output cpu_mem_req,
        output mem_rdata,
        input  fpga_sel,
        input  mem_we,
        input  mem_re,
        input  mem_addr,
        input  mem_wdata,
        input  rd_data,
        input  rd_valid,
        input  cpu_run,
        input  fifo_full,
        input  overflow
    );

endinterface

// File: rtl/fpga_mem_bridge.sv
// FPGA side of the shared data-memory port: turns level-style front-end writes into
// queued single-cycle stores, serves result reads and holds the CPU until operands land.
module fpga_mem_bridge #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic              hz100,
    input  logic              reset,
    fpga_mem_bridge_if.master bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RWAIT
    } state_t;

    state_t state_q, state_d;

    logic          prev_wr_en_q, prev_wr_en_d;
    logic [AW-1:0] prev_wr_addr_q, prev_wr_addr_d;
    logic [DW-1:0] prev_wr_data_q, prev_wr_data_d;
    logic          prev_rd_en_q, prev_rd_en_d;
    logic [AW-1:0] prev_rd_addr_q, prev_rd_addr_d;

    logic          cap_valid_q, cap_valid_d;
    logic [AW-1:0] cap_addr_q, cap_addr_d;
    logic [DW-1:0] cap_data_q, cap_data_d;

    logic [AW+DW-1:0] fifo_mem_q [DEPTH];
    logic [AW+DW-1:0] fifo_mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;

    logic          rd_pend_q, rd_pend_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;

    logic          fpga_sel_q, fpga_sel_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_re_q, mem_re_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          cpu_run_q, cpu_run_d;

    logic             capture;
    logic             rd_arm;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [AW+DW-1:0] fifo_head;

    // A held request level produces one entry; only a fresh level or new values count.
    always_comb begin
        capture    = bus.fpga_wr_en && (!prev_wr_en_q ||
                                        (bus.fpga_wr_addr != prev_wr_addr_q) ||
                                        (bus.fpga_wr_data != prev_wr_data_q));
        rd_arm     = bus.fpga_rd_en && (!prev_rd_en_q ||
                                        (bus.fpga_rd_addr != prev_rd_addr_q));
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
        fifo_head  = fifo_mem_q[rd_ptr_q[IW-1:0]];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!bus.cpu_mem_req) begin
                    if (!fifo_empty) begin
                        state_d = WRITE;
                    end else if (rd_pend_q) begin
                        state_d = READ;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            READ:    state_d = RWAIT;
            RWAIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port outputs are registered from the next state so the CPU sees ownership early;
    // the head entry is therefore popped on the edge that enters WRITE.
    always_comb begin
        prev_wr_en_d   = bus.fpga_wr_en;
        prev_wr_addr_d = bus.fpga_wr_addr;
        prev_wr_data_d = bus.fpga_wr_data;
        prev_rd_en_d   = bus.fpga_rd_en;
        prev_rd_addr_d = bus.fpga_rd_addr;

        cap_valid_d = capture;
        cap_addr_d  = bus.fpga_wr_addr;
        cap_data_d  = bus.fpga_wr_data;

        push       = cap_valid_q;
        pop        = (state_d == WRITE);
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            if (!fifo_full || pop) begin
                fifo_mem_d[wr_ptr_q[IW-1:0]] = {cap_addr_q, cap_data_q};
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        if (state_d == READ) begin
            rd_pend_d = 1'b0;
        end
        if (rd_arm) begin
            rd_pend_d = 1'b1;
            rd_addr_d = bus.fpga_rd_addr;
        end

        fpga_sel_d  = (state_d == WRITE) || (state_d == READ);
        mem_we_d    = (state_d == WRITE);
        mem_re_d    = (state_d == READ);
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d == WRITE) begin
            {mem_addr_d, mem_wdata_d} = fifo_head;
        end else if (state_d == READ) begin
            mem_addr_d = rd_addr_q;
        end

        rd_data_d  = (state_q == RWAIT) ? bus.mem_rdata : rd_data_q;
        rd_valid_d = (state_q == RWAIT);
        cpu_run_d  = bus.cpu_run_req && fifo_empty && !cap_valid_q && !capture &&
                     (state_q != WRITE);
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q        <= IDLE;
            prev_wr_en_q   <= 1'b0;
            prev_wr_addr_q <= '0;
            prev_wr_data_q <= '0;
            prev_rd_en_q   <= 1'b0;
            prev_rd_addr_q <= '0;
            cap_valid_q    <= 1'b0;
            cap_addr_q     <= '0;
            cap_data_q     <= '0;
            fifo_mem_q     <= '{default: '0};
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            overflow_q     <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_addr_q      <= '0;
            fpga_sel_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_re_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            cpu_run_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_wr_en_q   <= prev_wr_en_d;
            prev_wr_addr_q <= prev_wr_addr_d;
            prev_wr_data_q <= prev_wr_data_d;
            prev_rd_en_q   <= prev_rd_en_d;
            prev_rd_addr_q <= prev_rd_addr_d;
            cap_valid_q    <= cap_valid_d;
            cap_addr_q     <= cap_addr_d;
            cap_data_q     <= cap_data_d;
            fifo_mem_q     <= fifo_mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            overflow_q     <= overflow_d;
            rd_pend_q      <= rd_pend_d;
            rd_addr_q      <= rd_addr_d;
            fpga_sel_q     <= fpga_sel_d;
            mem_we_q       <= mem_we_d;
            mem_re_q       <= mem_re_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            cpu_run_q      <= cpu_run_d;
        end
    end

    assign bus.fpga_sel  = fpga_sel_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.cpu_run   = cpu_run_q;
    assign bus.fifo_full = fifo_full;
    assign bus.overflow  = overflow_q;

endmodule
